// File: rtl/sys_rf_pkg.sv
// Shared constants for the REF_CLK-domain system register file: config
// register addresses, their reset values and the UART_CFG field layout.
package sys_rf_pkg;

  localparam int ADDR_ALU_A     = 0;
  localparam int ADDR_ALU_B     = 1;
  localparam int ADDR_UART_CFG  = 2;
  localparam int ADDR_DIV_RATIO = 3;
  localparam int NUM_CFG        = 4;

  // UART_CFG reset 0x81 decodes as prescale 32, parity enabled, even parity
  localparam logic [7:0] RST_ALU_A     = 8'h00;
  localparam logic [7:0] RST_ALU_B     = 8'h01;
  localparam logic [7:0] RST_UART_CFG  = 8'h81;
  localparam logic [7:0] RST_DIV_RATIO = 8'h20;

  localparam int UART_PAR_EN_BIT   = 0;
  localparam int UART_PAR_TYPE_BIT = 1;
  localparam int UART_PRESCALE_LSB = 2;
  localparam int UART_PRESCALE_MSB = 7;

  function automatic logic [7:0] cfg_reset_value(input int idx);
    case (idx)
      ADDR_ALU_A:     return RST_ALU_A;
      ADDR_ALU_B:     return RST_ALU_B;
      ADDR_UART_CFG:  return RST_UART_CFG;
      ADDR_DIV_RATIO: return RST_DIV_RATIO;
      default:        return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/rf_rd_pipe.sv
// Read-return pipeline: RD_LAT stages of {valid, data}. Data stages only load
// behind a valid beat, so the final data stage holds between strobes.
module rf_rd_pipe #(
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data
);

  logic [RD_LAT-1:0] valid_q;
  logic [DATA_W-1:0] data_q [RD_LAT];

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < RD_LAT; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= req_valid;
      if (req_valid) data_q[0] <= req_data;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign rsp_valid = valid_q[RD_LAT-1];
  assign rsp_data  = data_q[RD_LAT-1];

endmodule

// File: rtl/reg_file_mp.sv
// System register file: config registers 0..3 (lockable) plus a clearable
// general-purpose area, with masked writes, read-first collisions and Err.
module reg_file_mp
  import sys_rf_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int RD_LAT = 1
) (
  input  logic              REF_CLK,
  input  logic              RST,
  input  logic              WrEn,
  input  logic              RdEn,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic [DATA_W-1:0] WrData,
  input  logic [DATA_W-1:0] WrMask,
  input  logic              LOCK,
  input  logic              CLR,
  output logic [DATA_W-1:0] RdData,
  output logic              RdData_Valid,
  output logic              Err,
  output logic [DATA_W-1:0] REG0,
  output logic [DATA_W-1:0] REG1,
  output logic [DATA_W-1:0] REG2,
  output logic [DATA_W-1:0] REG3
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [31:0]       addr_ext;
  logic              addr_ok;
  logic              is_cfg;
  logic              wr_illegal;
  logic              rd_illegal;
  logic              wr_go;
  logic [ADDR_W-1:0] rd_idx;
  logic [DATA_W-1:0] rd_word;
  logic              err_q;

  // DEPTH need not be a power of two, so the address space can exceed it.
  // CLR owns the general-purpose area, so a same-cycle GP write is dropped.
  assign addr_ext   = 32'(ADDRESS);
  assign addr_ok    = addr_ext < 32'(DEPTH);
  assign is_cfg     = addr_ext < 32'(NUM_CFG);
  assign wr_illegal = WrEn && (!addr_ok || (LOCK && is_cfg));
  assign rd_illegal = RdEn && !addr_ok;
  assign wr_go      = WrEn && !wr_illegal && !(CLR && !is_cfg);
  assign rd_idx     = addr_ok ? ADDRESS : '0;
  assign rd_word    = addr_ok ? mem[rd_idx] : '0;

  always_ff @(posedge REF_CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(cfg_reset_value(i));
    end else begin
      if (CLR) begin
        for (int i = NUM_CFG; i < DEPTH; i++) mem[i] <= '0;
      end
      if (wr_go) begin
        mem[ADDRESS] <= (mem[ADDRESS] & ~WrMask) | (WrData & WrMask);
      end
    end
  end

  // Err is a single registered strobe even when read and write both fault
  always_ff @(posedge REF_CLK) begin
    if (RST) err_q <= 1'b0;
    else     err_q <= wr_illegal || rd_illegal;
  end

  rf_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clock     (REF_CLK),
    .reset     (RST),
    .req_valid (RdEn),
    .req_data  (rd_word),
    .rsp_valid (RdData_Valid),
    .rsp_data  (RdData)
  );

  assign Err  = err_q;
  assign REG0 = mem[ADDR_ALU_A];
  assign REG1 = mem[ADDR_ALU_B];
  assign REG2 = mem[ADDR_UART_CFG];
  assign REG3 = mem[ADDR_DIV_RATIO];

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench: dut_a is DEPTH 16 / RD_LAT 1, dut_b is DEPTH 12 / RD_LAT 2,
// both driven by the same inputs.
module tb_reg_file_mp;

  logic       ref_clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [3:0] address = '0;
  logic [7:0] wr_data = '0;
  logic [7:0] wr_mask = '0;
  logic       lock = 1'b0;
  logic       clr = 1'b0;

  logic [7:0] rd_data_a, reg0_a, reg1_a, reg2_a, reg3_a;
  logic       rd_valid_a, err_a;
  logic [7:0] rd_data_b, reg0_b, reg1_b, reg2_b, reg3_b;
  logic       rd_valid_b, err_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 ref_clk = ~ref_clk;

  reg_file_mp #(.DATA_W(8), .DEPTH(16), .RD_LAT(1)) dut_a (
    .REF_CLK(ref_clk), .RST(rst), .WrEn(wr_en), .RdEn(rd_en), .ADDRESS(address),
    .WrData(wr_data), .WrMask(wr_mask), .LOCK(lock), .CLR(clr),
    .RdData(rd_data_a), .RdData_Valid(rd_valid_a), .Err(err_a),
    .REG0(reg0_a), .REG1(reg1_a), .REG2(reg2_a), .REG3(reg3_a));

  reg_file_mp #(.DATA_W(8), .DEPTH(12), .RD_LAT(2)) dut_b (
    .REF_CLK(ref_clk), .RST(rst), .WrEn(wr_en), .RdEn(rd_en), .ADDRESS(address),
    .WrData(wr_data), .WrMask(wr_mask), .LOCK(lock), .CLR(clr),
    .RdData(rd_data_b), .RdData_Valid(rd_valid_b), .Err(err_b),
    .REG0(reg0_b), .REG1(reg1_b), .REG2(reg2_b), .REG3(reg3_b));

  // Advance one edge; outputs are then sampled 1 ns after it
  task automatic step();
    @(posedge ref_clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0; wr_mask = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    step(); step();
    rst = 1'b0;
    n_cmp++; if (reg0_a !== 8'h00) begin n_bad++; $display("[TB] FAIL rst_reg0 got %h exp 00", reg0_a); end
    n_cmp++; if (reg1_a !== 8'h01) begin n_bad++; $display("[TB] FAIL rst_reg1 got %h exp 01", reg1_a); end
    n_cmp++; if (reg2_a !== 8'h81) begin n_bad++; $display("[TB] FAIL rst_reg2 got %h exp 81", reg2_a); end
    n_cmp++; if (reg3_a !== 8'h20) begin n_bad++; $display("[TB] FAIL rst_reg3 got %h exp 20", reg3_a); end
    n_cmp++; if (rd_valid_a !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_valid got %b exp 0", rd_valid_a); end
    n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_err got %b exp 0", err_a); end
    rd_en = 1'b1; address = 4'd9;
    step();
    idle();
    n_cmp++; if (rd_valid_a !== 1'b1) begin n_bad++; $display("[TB] FAIL rst_rd9_valid got %b exp 1", rd_valid_a); end
    n_cmp++; if (rd_data_a !== 8'h00) begin n_bad++; $display("[TB] FAIL rst_rd9_data got %h exp 00", rd_data_a); end
    step();
  endtask

  task automatic test_masked_write();
    wr_en = 1'b1; address = 4'd5; wr_data = 8'hA5; wr_mask = 8'hFF;
    step();
    wr_data = 8'h0F; wr_mask = 8'h0F;
    step();
    wr_data = 8'hFF; wr_mask = 8'h00;
    step();
    idle(); rd_en = 1'b1; address = 4'd5;
    step();
    idle();
    n_cmp++; if (rd_valid_a !== 1'b1) begin n_bad++; $display("[TB] FAIL mask_valid_a got %b exp 1", rd_valid_a); end
    n_cmp++; if (rd_data_a !== 8'hAF) begin n_bad++; $display("[TB] FAIL mask_data_a got %h exp AF", rd_data_a); end
    n_cmp++; if (rd_valid_b !== 1'b0) begin n_bad++; $display("[TB] FAIL mask_early_b got %b exp 0", rd_valid_b); end
    step();
    n_cmp++; if (rd_valid_a !== 1'b0) begin n_bad++; $display("[TB] FAIL mask_valid_a_drop got %b exp 0", rd_valid_a); end
    n_cmp++; if (rd_data_a !== 8'hAF) begin n_bad++; $display("[TB] FAIL mask_hold_a got %h exp AF", rd_data_a); end
    n_cmp++; if (rd_valid_b !== 1'b1) begin n_bad++; $display("[TB] FAIL mask_valid_b got %b exp 1", rd_valid_b); end
    n_cmp++; if (rd_data_b !== 8'hAF) begin n_bad++; $display("[TB] FAIL mask_data_b got %h exp AF", rd_data_b); end
    step();
    n_cmp++; if (rd_valid_b !== 1'b0) begin n_bad++; $display("[TB] FAIL mask_valid_b_drop got %b exp 0", rd_valid_b); end
  endtask

  task automatic test_collision();
    wr_en = 1'b1; address = 4'd6; wr_data = 8'h11; wr_mask = 8'hFF;
    step();
    wr_data = 8'h22; rd_en = 1'b1;
    step();
    n_cmp++; if (rd_data_a !== 8'h11) begin n_bad++; $display("[TB] FAIL coll_first got %h exp 11", rd_data_a); end
    wr_en = 1'b0;
    step();
    idle();
    n_cmp++; if (rd_valid_a !== 1'b1) begin n_bad++; $display("[TB] FAIL coll_b2b_valid got %b exp 1", rd_valid_a); end
    n_cmp++; if (rd_data_a !== 8'h22) begin n_bad++; $display("[TB] FAIL coll_second got %h exp 22", rd_data_a); end
    step();
  endtask

  task automatic test_lock();
    lock = 1'b1; wr_en = 1'b1; address = 4'd3; wr_data = 8'h40; wr_mask = 8'hFF;
    step();
    idle();
    n_cmp++; if (err_a !== 1'b1) begin n_bad++; $display("[TB] FAIL lock_err got %b exp 1", err_a); end
    n_cmp++; if (reg3_a !== 8'h20) begin n_bad++; $display("[TB] FAIL lock_reg3 got %h exp 20", reg3_a); end
    step();
    n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("[TB] FAIL lock_err_once got %b exp 0", err_a); end
    lock = 1'b0; wr_en = 1'b1; wr_mask = 8'hFF;
    step();
    idle();
    n_cmp++; if (reg3_a !== 8'h40) begin n_bad++; $display("[TB] FAIL unlock_reg3 got %h exp 40", reg3_a); end
    n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("[TB] FAIL unlock_err got %b exp 0", err_a); end
  endtask

  task automatic test_clear();
    for (int i = 4; i < 16; i++) begin
      wr_en = 1'b1; address = 4'(i); wr_data = 8'(8'h30 + i); wr_mask = 8'hFF;
      step();
    end
    clr = 1'b1; wr_en = 1'b1; address = 4'd7; wr_data = 8'h77; wr_mask = 8'hFF;
    step();
    idle();
    for (int i = 4; i < 16; i++) begin
      rd_en = 1'b1; address = 4'(i);
      step();
      n_cmp++; if (rd_data_a !== 8'h00) begin n_bad++; $display("[TB] FAIL clr_addr%0d got %h exp 00", i, rd_data_a); end
    end
    idle();
    n_cmp++; if (reg0_a !== 8'h00 || reg1_a !== 8'h01 || reg2_a !== 8'h81 || reg3_a !== 8'h40) begin
      n_bad++; $display("[TB] FAIL clr_cfg got %h %h %h %h exp 00 01 81 40", reg0_a, reg1_a, reg2_a, reg3_a);
    end
    step(); step();
  endtask

  task automatic test_out_of_range();
    rd_en = 1'b1; wr_en = 1'b1; address = 4'd13; wr_data = 8'h55; wr_mask = 8'hFF;
    step();
    idle();
    n_cmp++; if (err_b !== 1'b1) begin n_bad++; $display("[TB] FAIL oor_err got %b exp 1", err_b); end
    n_cmp++; if (rd_valid_b !== 1'b0) begin n_bad++; $display("[TB] FAIL oor_early got %b exp 0", rd_valid_b); end
    n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("[TB] FAIL oor_a_legal got %b exp 0", err_a); end
    step();
    n_cmp++; if (err_b !== 1'b0) begin n_bad++; $display("[TB] FAIL oor_err_single got %b exp 0", err_b); end
    n_cmp++; if (rd_valid_b !== 1'b1) begin n_bad++; $display("[TB] FAIL oor_valid got %b exp 1", rd_valid_b); end
    n_cmp++; if (rd_data_b !== 8'h00) begin n_bad++; $display("[TB] FAIL oor_data got %h exp 00", rd_data_b); end
    step();
  endtask

  task automatic test_reset_mid_read();
    rd_en = 1'b1; address = 4'd2;
    step();
    idle(); rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (rd_valid_b !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_flush_c%0d got %b exp 0", c, rd_valid_b); end
      step();
    end
    n_cmp++; if (reg3_b !== 8'h20) begin n_bad++; $display("[TB] FAIL rst_flush_reg3 got %h exp 20", reg3_b); end
  endtask

  initial begin
    test_reset();
    test_masked_write();
    test_collision();
    test_lock();
    test_clear();
    test_out_of_range();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised successor register file for the multi-clock system's REF_CLK domain. It holds the system configuration registers (ALU operands, UART config, clock-divider ratio) plus a general-purpose store, all addressed by the system controller. Beyond plain write/read, it adds:
- bit-masked writes
- configurable read latency
- write-protect lock on the config registers
- bulk clear of the general-purpose area
- an error flag for illegal accesses

## Interface
Parameters:
- DATA_W, 8, register width in bits (≥ 8).
- DEPTH, 16, number of registers (≥ 5; need not be a power of two).
- ADDR_W, $clog2(DEPTH), address width (derived).
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.

Ports:
- REF_CLK  in  1  sole clock; all logic on its rising edge.
- RST  in  1  synchronous, active-high reset.
- WrEn  in  1  write request.
- RdEn  in  1  read request.
- ADDRESS  in  ADDR_W  register address.
- WrData  in  DATA_W  write data.
- WrMask  in  DATA_W  per-bit write enable; 1 = bit is updated.
- LOCK  in  1  when high, writes to config addresses 0–3 are rejected.
- CLR  in  1  one-cycle request to zero addresses 4..DEPTH-1.
- RdData  out  DATA_W  read data.
- RdData_Valid  out  1  one-cycle strobe qualifying RdData.
- Err  out  1  one-cycle illegal-access strobe.
- REG0, REG1, REG2, REG3  out  DATA_W each  live contents of addresses 0–3.

## Operation
- Reset (RST high at an edge):
  - REG0 = 0x00, REG1 = 0x01, REG2 = 0x81 (prescale 32, parity enabled, even parity), REG3 = 0x20 (divide ratio 32).
  - Addresses 4..DEPTH-1 = 0.
  - RdData = 0, RdData_Valid = 0, Err = 0.
  - Read pipeline flushed; in-flight reads are dropped and never strobe valid.
- Write (WrEn sampled high): mem[ADDRESS] ← (mem & ~WrMask) | (WrData & WrMask). WrMask = 0 is legal and leaves the register unchanged.
- Read (RdEn sampled high): the array is sampled at that edge. Back-to-back reads, one per cycle, are supported.
- WrEn and RdEn both high: both operations are performed. Read-first ordering: the read returns the pre-write value even when the addresses match.
- Illegal access: a write is not performed and Err strobes when either
  - ADDRESS ≥ DEPTH, or
  - LOCK = 1 and ADDRESS < 4.
- Illegal read: ADDRESS ≥ DEPTH. RdData_Valid still strobes with RdData = 0, and Err strobes.
- A simultaneous illegal write and illegal read produce a single Err strobe.
- CLR:
  - Zeroes addresses 4..DEPTH-1 at the sampling edge; config registers are untouched.
  - Beats any same-cycle write to 4..DEPTH-1. A same-cycle write to 0–3 proceeds, subject to LOCK.
  - A same-cycle read returns the pre-clear value.
- LOCK has no effect on reads or on CLR.
- REG0–REG3 are continuous views of the array; no extra latency.

## Timing
- Write latency: register value and REGx outputs update on the edge that samples WrEn and are visible in the next cycle.
- Read latency: RdData and RdData_Valid are asserted RD_LAT cycles after the sampling edge. For RD_LAT = 1 they appear in the cycle immediately after the request.
- RdData_Valid is high for exactly one cycle per accepted read. RdData holds its last value when valid is low.
- Err is asserted in the cycle after the offending request, independent of RD_LAT.
- RST has priority over all other inputs at any edge.

## Structure
- Package sys_rf_pkg holds:
  - address constants: ADDR_ALU_A = 0, ADDR_ALU_B = 1, ADDR_UART_CFG = 2, ADDR_DIV_RATIO = 3, NUM_CFG = 4;
  - config reset constants: 0x00, 0x01, 0x81, 0x20;
  - UART_CFG field positions: bit 0 parity enable, bit 1 parity type, bits 7:2 prescale.
- Sub-module rf_rd_pipe: parametrised RD_LAT-stage shift of {valid, data} with synchronous reset. Instantiated once.

## Test plan
- Reset: drive RST for 2 cycles → REG0..3 = 00/01/81/20; address 9 reads 0x00; RdData_Valid = 0; Err = 0.
- Masked write: write 0xA5 to address 5 with WrMask = 0xFF, then write 0x0F with WrMask = 0x0F → a read of address 5 returns 0xAF; valid asserts exactly RD_LAT cycles after RdEn.
- Collision: address 6 holds 0x11; in the same cycle write 0x22 to address 6 and read address 6 → read returns 0x11; a following read returns 0x22.
- Lock: with LOCK = 1, write 0x40 to address 3 → REG3 stays 0x20 and Err strobes once. With LOCK = 0, the same write → REG3 = 0x40 and Err = 0.
- Clear and out-of-range:
  - Fill addresses 4..15, assert CLR together with a write of 0x77 to address 7 → all of 4..15 read 0 and config registers are unchanged.
  - With DEPTH = 12, read address 13 → RdData = 0, valid strobes, Err strobes.
- Reset mid-read: with RD_LAT = 2, issue RdEn and assert RST on the next edge → no RdData_Valid strobe follows.
